// File: rtl/serial_tx_unit_pkg.sv
// Shared definitions for the serial transmit stage: FSM state codes and frame-length helper.
package serial_tx_unit_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Clk cycles from the sampled start edge to the TxDone pulse.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int parity_en, input int stop_bits);
    return clks_per_bit * (1 + data_w + parity_en + stop_bits) + 1;
  endfunction

endpackage

// File: rtl/serial_tx_unit_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (clear || cnt == TC)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/serial_tx_unit.sv
// UART-style frame serialiser: one frame per TxData rising edge, TxDone pulse on completion.
//   state  | meaning
//   IDLE   | line high, waiting for a start edge
//   START  | start bit (low) for one bit period
//   DATA   | DATA_W payload bits, LSB first
//   PARITY | optional parity bit
//   STOP   | STOP_BITS stop bits (high)
//   DONE   | single cycle, TxDone asserted; a new start edge is accepted here
module serial_tx_unit
  import serial_tx_unit_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TxData,
  input  logic [DATA_W-1:0] DataIn,
  output logic              TxOut,
  output logic              TxBusy,
  output logic              TxDone,
  output logic              Overrun
);

  localparam int BW = $clog2(DATA_W + 1);

  logic [2:0]        state, state_nxt;
  logic              req_q;
  logic              start, accept;
  logic              tick, clear;
  logic [DATA_W-1:0] sh;
  logic              par_q;
  logic [BW-1:0]     bit_cnt;
  logic              ovr_q;

  assign start  = TxData & ~req_q;
  assign accept = start && (state == IDLE || state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_cnt == BW'(DATA_W - 1))
                 state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick && bit_cnt == BW'(STOP_BITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restart the bit timer whenever a new state begins so every phase gets full bit periods.
  assign clear = (state_nxt != state);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      sh      <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= TxData;
      ovr_q <= start && !accept;
      if (accept) begin
        sh    <= DataIn;
        par_q <= (^DataIn) ^ (PARITY_ODD != 0);
      end else if (state == DATA && tick) begin
        sh <= sh >> 1;
      end
      if (clear)
        bit_cnt <= '0;
      else if (tick && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Outputs are a registered decode of the state, so the line never glitches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TxOut   <= 1'b1;
      TxBusy  <= 1'b0;
      TxDone  <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      TxBusy  <= (state != IDLE);
      TxDone  <= (state == DONE);
      Overrun <= ovr_q;
      case (state)
        START:   TxOut <= 1'b0;
        DATA:    TxOut <= sh[0];
        PARITY:  TxOut <= par_q;
        default: TxOut <= 1'b1;
      endcase
    end
  end

endmodule
